// File: rtl/avl_bus_wrr_arb.sv
// Weighted round-robin, burst-aware master select for the N-to-1 Avalon concentrator.
// Registered sel/grant_valid/locked; write bursts hold the grant until the final beat.

module avl_bus_wrr_arb_lane #(
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic [WEIGHT_WIDTH-1:0] weight,
    output logic [WEIGHT_WIDTH-1:0] load
);
    assign load = (weight == '0) ? WEIGHT_WIDTH'(1) : weight;
endmodule

module avl_bus_wrr_arb #(
    parameter int MASTER_NUM   = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int BURST_WIDTH  = 8,
    parameter int SEL_WIDTH    = $clog2(MASTER_NUM)
) (
    input  logic                               clk,
    input  logic                               rest,
    input  logic [MASTER_NUM-1:0]              request,
    input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weight,
    input  logic                               out_read,
    input  logic                               out_write,
    input  logic                               out_request_ready,
    input  logic                               out_begin_burst,
    input  logic [BURST_WIDTH-1:0]             out_burst_count,
    output logic [SEL_WIDTH-1:0]               sel,
    output logic                               grant_valid,
    output logic                               locked
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_d, last_q, last_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d, credit_dec;
    logic [BURST_WIDTH-1:0]  beats_q, beats_d;

    logic [MASTER_NUM-1:0][WEIGHT_WIDTH-1:0] weight_arr, load_arr;
    assign weight_arr = weight;

    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_lane
        avl_bus_wrr_arb_lane #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_lane (
            .weight (weight_arr[i]),
            .load   (load_arr[i])
        );
    end

    logic acc, burst_start, cmd_done;
    logic any_found, other_found;
    logic [SEL_WIDTH-1:0] any_idx, other_idx;

    assign acc         = grant_valid & out_request_ready & (out_read | out_write);
    assign burst_start = out_write & out_begin_burst & (out_burst_count > BURST_WIDTH'(1));
    assign credit_dec  = (credit_q == '0) ? '0 : credit_q - WEIGHT_WIDTH'(1);

    function automatic logic [SEL_WIDTH-1:0] rr_idx(input logic [SEL_WIDTH-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % MASTER_NUM;
        return SEL_WIDTH'(sum);
    endfunction

    // Descending scan: the lowest cyclic offset from last+1 is written last and wins.
    // The "other" search stops one short so the current owner (== last) is excluded.
    always_comb begin
        any_found   = 1'b0;
        any_idx     = '0;
        other_found = 1'b0;
        other_idx   = '0;
        for (int off = MASTER_NUM; off >= 1; off--) begin
            if (request[rr_idx(last_q, off)]) begin
                any_found = 1'b1;
                any_idx   = rr_idx(last_q, off);
            end
        end
        for (int off = MASTER_NUM - 1; off >= 1; off--) begin
            if (request[rr_idx(last_q, off)]) begin
                other_found = 1'b1;
                other_idx   = rr_idx(last_q, off);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel;
        last_d   = last_q;
        credit_d = credit_q;
        beats_d  = beats_q;
        cmd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_found) begin
                    state_d  = GRANT;
                    sel_d    = any_idx;
                    last_d   = any_idx;
                    credit_d = load_arr[any_idx];
                end
            end
            GRANT: begin
                if (acc) begin
                    if (burst_start) begin
                        state_d  = LOCK;
                        beats_d  = out_burst_count - BURST_WIDTH'(1);
                        credit_d = credit_dec;
                    end else begin
                        cmd_done = 1'b1;
                    end
                end else if (!request[sel]) begin
                    if (any_found) begin
                        sel_d    = any_idx;
                        last_d   = any_idx;
                        credit_d = load_arr[any_idx];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                if (acc) begin
                    if (beats_q == BURST_WIDTH'(1)) begin
                        beats_d  = '0;
                        cmd_done = 1'b1;
                    end else begin
                        beats_d = beats_q - BURST_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Last credit spent: hand over if someone waits, else start a fresh turn in place.
        if (cmd_done) begin
            state_d = GRANT;
            if (credit_q <= WEIGHT_WIDTH'(1)) begin
                if (other_found) begin
                    sel_d    = other_idx;
                    last_d   = other_idx;
                    credit_d = load_arr[other_idx];
                end else begin
                    credit_d = load_arr[sel];
                end
            end else begin
                credit_d = credit_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q     <= IDLE;
            sel         <= '0;
            last_q      <= SEL_WIDTH'(MASTER_NUM - 1);
            credit_q    <= '0;
            beats_q     <= '0;
            grant_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            last_q      <= last_d;
            credit_q    <= credit_d;
            beats_q     <= beats_d;
            grant_valid <= (state_d != IDLE);
            locked      <= (state_d == LOCK);
        end
    end
endmodule

// File: tb/tb_avl_bus_wrr_arb.sv
// Directed test-plan steps followed by random traffic, all checked against a turn/credit model.

module tb_avl_bus_wrr_arb;
    localparam int N  = 4;
    localparam int WW = 4;
    localparam int BW = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rest;
    logic [N-1:0]  request;
    logic [N*WW-1:0] weight;
    logic          out_read, out_write, out_request_ready, out_begin_burst;
    logic [BW-1:0] out_burst_count;
    logic [SW-1:0] sel;
    logic          grant_valid, locked;

    int n_assert = 0;
    int n_fail   = 0;

    avl_bus_wrr_arb #(.MASTER_NUM(N), .WEIGHT_WIDTH(WW), .BURST_WIDTH(BW)) dut (
        .clk               (clk),
        .rest              (rest),
        .request           (request),
        .weight            (weight),
        .out_read          (out_read),
        .out_write         (out_write),
        .out_request_ready (out_request_ready),
        .out_begin_burst   (out_begin_burst),
        .out_burst_count   (out_burst_count),
        .sel               (sel),
        .grant_valid       (grant_valid),
        .locked            (locked)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, how many commands remain in its turn, beats left in a locked write.
    int m_owner, m_last, m_left, m_beats;
    bit m_active, m_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int turn_len(int k);
        int w;
        w = int'((weight >> (k * WW)) & 16'hF);
        return (w == 0) ? 1 : w;
    endfunction

    // First requester after 'after' in circular order, looking at up to 'span' masters.
    function automatic int first_req(int after, int span);
        for (int off = 1; off <= span; off++)
            if (request[(after + off) % N]) return (after + off) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = N - 1; m_left = 0; m_beats = 0;
        m_active = 0; m_lock = 0;
    endtask

    task automatic give_to(int k);
        m_owner = k; m_last = k; m_left = turn_len(k);
        m_active = 1; m_lock = 0;
    endtask

    task automatic command_finished();
        int nx;
        m_lock = 0;
        if (m_left <= 1) begin
            nx = first_req(m_last, N - 1);
            if (nx >= 0) give_to(nx);
            else m_left = turn_len(m_owner);
        end else begin
            m_left--;
        end
    endtask

    task automatic model_step();
        bit acc;
        int nx;
        acc = m_active && out_request_ready && (out_read || out_write);
        if (!m_active) begin
            nx = first_req(m_last, N);
            if (nx >= 0) give_to(nx);
        end else if (m_lock) begin
            if (acc) begin
                if (m_beats <= 1) command_finished();
                else m_beats--;
            end
        end else if (acc) begin
            if (out_write && out_begin_burst && out_burst_count > 1) begin
                m_lock  = 1;
                m_beats = int'(out_burst_count) - 1;
                if (m_left > 0) m_left--;
            end else begin
                command_finished();
            end
        end else if (!request[m_owner]) begin
            nx = first_req(m_last, N);
            if (nx >= 0) give_to(nx);
            else m_active = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("grant_valid", grant_valid, m_active);
        chk("locked", locked, m_lock);
        chk("sel", sel, m_owner);
    endtask

    task automatic idle_inputs();
        request = '0; out_read = 0; out_write = 0; out_request_ready = 0;
        out_begin_burst = 0; out_burst_count = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rest = 1'b0;
        model_reset();
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_gv", grant_valid, 0);
        chk("rst_locked", locked, 0);
        @(posedge clk);
        #1;
        rest = 1'b1;
    endtask

    int exp_order [10] = '{0, 0, 0, 1, 1, 2, 3, 0, 0, 0};

    initial begin
        weight = 16'h1111;
        do_reset();

        // Basic grant: one request, grant the next cycle
        tick();
        request = 4'b0100;
        tick();
        chk("basic_sel", sel, 2);
        chk("basic_gv", grant_valid, 1);

        // Weighted rotation with weights m3..m0 = 1,1,2,3
        do_reset();
        weight = 16'h1123;
        request = 4'b1111;
        tick();
        out_read = 1; out_request_ready = 1;
        for (int i = 0; i < 10; i++) begin
            chk("rot_order", sel, exp_order[i]);
            tick();
        end

        // Write burst lock on m1 with m2 waiting
        do_reset();
        weight = 16'h1111;
        request = 4'b0110;
        tick();
        chk("wb_first", sel, 1);
        out_write = 1; out_begin_burst = 1; out_burst_count = 8'd4; out_request_ready = 1;
        tick();
        chk("wb_locked", locked, 1);
        out_begin_burst = 0; out_request_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wb_stall_sel", sel, 1);
        end
        out_request_ready = 1;
        tick();
        tick();
        chk("wb_beat3_sel", sel, 1);
        tick();
        chk("wb_handover", sel, 2);
        chk("wb_unlocked", locked, 0);

        // Read burst is not locked
        do_reset();
        weight = 16'h1111;
        request = 4'b0011;
        tick();
        out_read = 1; out_begin_burst = 1; out_burst_count = 8'd8; out_request_ready = 1;
        tick();
        chk("rb_sel", sel, 1);
        chk("rb_locked", locked, 0);

        // Backpressure holds sel; weight 0 on m3 means a single command per turn
        do_reset();
        weight = 16'h0001;
        request = 4'b1001;
        tick();
        out_read = 1; out_request_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", sel, 0);
        end
        out_request_ready = 1;
        tick();
        chk("bp_to_m3", sel, 3);
        tick();
        chk("bp_back_m0", sel, 0);

        // Reset during the second beat of a locked write
        do_reset();
        weight = 16'h1111;
        request = 4'b0011;
        tick();
        out_write = 1; out_begin_burst = 1; out_burst_count = 8'd4; out_request_ready = 1;
        tick();
        chk("rl_locked", locked, 1);
        out_begin_burst = 0;
        #2;
        rest = 1'b0;
        model_reset();
        #1;
        chk("rl_sel", sel, 0);
        chk("rl_gv", grant_valid, 0);
        chk("rl_locked0", locked, 0);
        idle_inputs();
        request = 4'b1000;
        @(posedge clk);
        #1;
        rest = 1'b1;
        tick();
        chk("rl_after", sel, 3);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) request = N'($urandom);
            if ($urandom_range(0, 15) == 0) weight = (N * WW)'($urandom);
            out_request_ready = ($urandom_range(0, 3) != 0);
            out_read          = 1'($urandom);
            out_write         = 1'($urandom);
            out_begin_burst   = 1'($urandom);
            out_burst_count   = BW'($urandom_range(0, 5));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
